// File: rtl/spi_burst_ctrl.sv
// Burst sequencer that feeds an SPI byte master from a TX FIFO and collects
// returned bytes into an RX FIFO, with a per-byte response timeout.
module spi_burst_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [3:0] burst_len,
  input  logic       burst_start,
  output logic       busy,
  output logic       burst_done,
  output logic       burst_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] m_tx_data,
  output logic       m_start,
  input  logic [7:0] m_rx_data,
  input  logic       m_rx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [3:0]      rem_r;
  logic [TW-1:0]   tcnt_r;
  logic            err_r, err_nxt_s;
  logic            rx_done_prev_r;
  logic            busy_r, done_r, berr_r, m_start_r;
  logic [7:0]      m_tx_data_r;
  logic            busy_nxt_s, done_nxt_s, berr_nxt_s, m_start_nxt_s;
  logic [7:0]      m_tx_nxt_s;

  logic [7:0]      tx_mem_r [DEPTH];
  logic [AW-1:0]   tx_wr_r, tx_rd_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [7:0]      rx_mem_r [DEPTH];
  logic [AW-1:0]   rx_wr_r, rx_rd_r;
  logic [CW-1:0]   rx_cnt_r;

  logic tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
  logic rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
  logic edge_s, tmo_s;

  assign tx_full_s  = (tx_cnt_r == CW'(DEPTH));
  assign tx_empty_s = (tx_cnt_r == {CW{1'b0}});
  assign rx_full_s  = (rx_cnt_r == CW'(DEPTH));
  assign rx_empty_s = (rx_cnt_r == {CW{1'b0}});
  assign tx_push_s  = tx_valid && !tx_full_s;
  assign tx_pop_s   = (state_r == S_LOAD) && !tx_empty_s;
  assign rx_push_s  = (state_r == S_STORE) && !rx_full_s;
  assign rx_pop_s   = rx_ready && !rx_empty_s;
  assign edge_s     = m_rx_done && !rx_done_prev_r;
  assign tmo_s      = (tcnt_r == TW'(TIMEOUT - 1));

  assign tx_ready   = !tx_full_s;
  assign rx_valid   = !rx_empty_s;
  assign busy       = busy_r;
  assign burst_done = done_r;
  assign burst_err  = berr_r;
  assign m_start    = m_start_r;
  assign m_tx_data  = m_tx_data_r;

  // RX head is presented combinationally; zero while the FIFO is empty
  always_comb begin
    if (rx_empty_s) rx_data = 8'd0;
    else            rx_data = rx_mem_r[rx_rd_r];
  end

  // TX FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) tx_mem_r[i] <= 8'd0;
      tx_wr_r  <= {AW{1'b0}};
      tx_rd_r  <= {AW{1'b0}};
      tx_cnt_r <= {CW{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_r] <= tx_data;
        tx_wr_r           <= tx_wr_r + AW'(1);
      end
      if (tx_pop_s) tx_rd_r <= tx_rd_r + AW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CW'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - CW'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rx_mem_r[i] <= 8'd0;
      rx_wr_r  <= {AW{1'b0}};
      rx_rd_r  <= {AW{1'b0}};
      rx_cnt_r <= {CW{1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_r] <= m_rx_data;
        rx_wr_r           <= rx_wr_r + AW'(1);
      end
      if (rx_pop_s) rx_rd_r <= rx_rd_r + AW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CW'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - CW'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // Next-state logic; a response edge wins over a coincident timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (burst_start && (burst_len != 4'd0)) state_nxt_s = S_LOAD;
        else                                    state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (!tx_empty_s) state_nxt_s = S_WAIT;
        else             state_nxt_s = S_LOAD;
      end
      S_WAIT: begin
        if (edge_s)     state_nxt_s = S_STORE;
        else if (tmo_s) state_nxt_s = S_DONE;
        else            state_nxt_s = S_WAIT;
      end
      S_STORE: begin
        if (rx_full_s)          state_nxt_s = S_STORE;
        else if (rem_r == 4'd1) state_nxt_s = S_DONE;
        else                    state_nxt_s = S_LOAD;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the error flag
  always_comb begin
    busy_nxt_s    = (state_nxt_s != S_IDLE);
    done_nxt_s    = (state_nxt_s == S_DONE);
    m_start_nxt_s = tx_pop_s;
    err_nxt_s     = err_r;
    if ((state_r == S_WAIT) && !edge_s && tmo_s) err_nxt_s = 1'b1;
    else if (state_r == S_DONE)                  err_nxt_s = 1'b0;
    else                                         err_nxt_s = err_r;
    berr_nxt_s = done_nxt_s && err_nxt_s;
    if (tx_pop_s) m_tx_nxt_s = tx_mem_r[tx_rd_r];
    else          m_tx_nxt_s = m_tx_data_r;
  end

  // State, burst counters and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      rem_r          <= 4'd0;
      tcnt_r         <= {TW{1'b0}};
      err_r          <= 1'b0;
      rx_done_prev_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      berr_r         <= 1'b0;
      m_start_r      <= 1'b0;
      m_tx_data_r    <= 8'd0;
    end else begin
      state_r        <= state_nxt_s;
      err_r          <= err_nxt_s;
      rx_done_prev_r <= m_rx_done;
      busy_r         <= busy_nxt_s;
      done_r         <= done_nxt_s;
      berr_r         <= berr_nxt_s;
      m_start_r      <= m_start_nxt_s;
      m_tx_data_r    <= m_tx_nxt_s;
      if ((state_r == S_IDLE) && (state_nxt_s == S_LOAD)) rem_r <= burst_len;
      else if (rx_push_s)                                 rem_r <= rem_r - 4'd1;
      else                                                rem_r <= rem_r;
      if (state_r == S_WAIT) tcnt_r <= tcnt_r + TW'(1);
      else                   tcnt_r <= {TW{1'b0}};
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl: the bench plays host and SPI master,
// checking every step against hand-computed values.
module tb_spi_burst_ctrl;

  logic       clk, reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [3:0] burst_len;
  logic       burst_start, busy, burst_done, burst_err;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] m_tx_data;
  logic       m_start;
  logic [7:0] m_rx_data;
  logic       m_rx_done;

  int vecs = 0;
  int miss = 0;
  int mstart_cnt = 0;
  int done_cnt = 0;
  int done_snap;
  int ms_snap;
  int n;

  spi_burst_ctrl #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .burst_len(burst_len), .burst_start(burst_start),
    .busy(busy), .burst_done(burst_done), .burst_err(burst_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .m_tx_data(m_tx_data), .m_start(m_start),
    .m_rx_data(m_rx_data), .m_rx_done(m_rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_start) mstart_cnt++;
    if (burst_done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic start(input logic [3:0] len);
    burst_len = len;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
  endtask

  task automatic pop_chk(input logic [7:0] exp, input string tag);
    chk({tag, "_valid"}, rx_valid, 1);
    chk(tag, rx_data, exp);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_mstart(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_start) found = 1'b1;
      else tick();
    end
    chk({tag, "_mstart_seen"}, found, 1);
  endtask

  // Serve one byte as the SPI master: check the launched byte, answer after one cycle
  task automatic do_byte(input logic [7:0] exp_tx, input logic [7:0] rxb, input string tag);
    wait_mstart(tag);
    chk({tag, "_mtx"}, m_tx_data, exp_tx);
    tick();
    chk({tag, "_mstart_pulse"}, m_start, 0);
    chk({tag, "_mtx_hold"}, m_tx_data, exp_tx);
    m_rx_data = rxb;
    m_rx_done = 1'b1;
    tick();
    m_rx_done = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (burst_done) found = 1'b1;
      else tick();
    end
    chk({tag, "_done_seen"}, found, 1);
    chk({tag, "_err"}, burst_err, exp_err);
    tick();
    chk({tag, "_done_pulse"}, burst_done, 0);
    chk({tag, "_err_pulse"}, burst_err, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; tx_data = 8'd0; tx_valid = 1'b0; burst_len = 4'd0; burst_start = 1'b0;
    rx_ready = 1'b0; m_rx_data = 8'd0; m_rx_done = 1'b0;
    tick(); tick(); tick();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_err", burst_err, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_m_tx_data", m_tx_data, 0);
    chk("rst_m_start", m_start, 0);
    reset = 1'b1;
    tick();

    // Single byte burst
    push(8'hB7);
    start(4'd1);
    chk("t1_busy", busy, 1);
    do_byte(8'hB7, 8'hAD, "t1");
    wait_done(1'b0, "t1");
    pop_chk(8'hAD, "t1_rx");
    chk("t1_rx_empty", rx_valid, 0);
    chk("t1_mstart_cnt", mstart_cnt, 1);

    // Zero length start is ignored
    start(4'd0);
    tick();
    chk("len0_busy", busy, 0);
    chk("len0_mstart_cnt", mstart_cnt, 1);

    // Fill TX FIFO, overflow push ignored, 4-byte burst
    push(8'hFB); push(8'h89); push(8'h01); push(8'h02);
    chk("t2_full", tx_ready, 0);
    push(8'h55);
    chk("t2_still_full", tx_ready, 0);
    start(4'd4);
    do_byte(8'hFB, 8'h11, "t2b0");
    do_byte(8'h89, 8'h22, "t2b1");
    do_byte(8'h01, 8'h33, "t2b2");
    do_byte(8'h02, 8'h44, "t2b3");
    wait_done(1'b0, "t2");
    chk("t2_mstart_cnt", mstart_cnt, 5);
    chk("t2_tx_ready", tx_ready, 1);
    pop_chk(8'h11, "t2_rx0"); pop_chk(8'h22, "t2_rx1");
    pop_chk(8'h33, "t2_rx2"); pop_chk(8'h44, "t2_rx3");
    chk("t2_rx_empty", rx_valid, 0);

    // Stall in LOAD on empty TX FIFO; a start mid-burst is ignored
    push(8'hA1);
    start(4'd3);
    do_byte(8'hA1, 8'h5A, "t3b0");
    ms_snap = mstart_cnt;
    done_snap = done_cnt;
    start(4'd5);
    for (int i = 0; i < 6; i++) tick();
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_mstart", mstart_cnt, ms_snap);
    chk("t3_stall_done", done_cnt, done_snap);
    push(8'hA2);
    do_byte(8'hA2, 8'h5B, "t3b1");
    push(8'hA3);
    do_byte(8'hA3, 8'h5C, "t3b2");
    wait_done(1'b0, "t3");
    chk("t3_mstart_cnt", mstart_cnt, ms_snap + 2);
    pop_chk(8'h5A, "t3_rx0"); pop_chk(8'h5B, "t3_rx1"); pop_chk(8'h5C, "t3_rx2");

    // Timeout: no response for TIMEOUT cycles
    push(8'hC3);
    start(4'd1);
    wait_mstart("t4");
    n = 0;
    while (!burst_done && n < 200) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 64);
    chk("t4_err", burst_err, 1);
    tick();
    chk("t4_busy", busy, 0);
    chk("t4_err_pulse", burst_err, 0);
    chk("t4_rx_empty", rx_valid, 0);

    // RX backpressure: stall in STORE with a full RX FIFO
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    start(4'd6);
    do_byte(8'hD0, 8'h60, "t5b0");
    push(8'hD4);
    do_byte(8'hD1, 8'h61, "t5b1");
    push(8'hD5);
    do_byte(8'hD2, 8'h62, "t5b2");
    do_byte(8'hD3, 8'h63, "t5b3");
    do_byte(8'hD4, 8'h64, "t5b4");
    done_snap = done_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_stall_busy", busy, 1);
    chk("t5_stall_done", done_cnt, done_snap);
    pop_chk(8'h60, "t5_rx0");
    do_byte(8'hD5, 8'h65, "t5b5");
    tick(); tick();
    chk("t5_stall2_busy", busy, 1);
    pop_chk(8'h61, "t5_rx1");
    wait_done(1'b0, "t5");
    pop_chk(8'h62, "t5_rx2"); pop_chk(8'h63, "t5_rx3");
    pop_chk(8'h64, "t5_rx4"); pop_chk(8'h65, "t5_rx5");
    chk("t5_rx_empty", rx_valid, 0);

    // Reset during WAIT of a 3-byte burst
    push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
    start(4'd3);
    do_byte(8'hE0, 8'h70, "t6b0");
    push(8'hE4);
    wait_mstart("t6b1");
    push(8'hE5);
    chk("t6_pre_full", tx_ready, 0);
    chk("t6_pre_rx", rx_valid, 1);
    chk("t6_pre_busy", busy, 1);
    done_snap = done_cnt;
    reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_tx_ready", tx_ready, 1);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_m_start", m_start, 0);
    chk("t6_m_tx_data", m_tx_data, 0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_done", done_cnt, done_snap);
    chk("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/spi_burst_ctrl.md
SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, entries per TX and RX FIFO (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 64, max cycles to wait for m_rx_done per byte.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  host byte to queue for transmission.
REQ-006 tx_valid  input  1  host byte valid; push when tx_valid && tx_ready.
REQ-007 tx_ready  output  1  TX FIFO not full.
REQ-008 burst_len  input  4  bytes in burst, sampled on accepted burst_start.
REQ-009 burst_start  input  1  request burst; accepted only in IDLE with burst_len != 0.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 burst_done  output  1  one-cycle pulse at burst end.
REQ-012 burst_err  output  1  one-cycle pulse with burst_done when burst aborted by timeout.
REQ-013 rx_data  output  8  head of RX FIFO.
REQ-014 rx_valid  output  1  RX FIFO not empty.
REQ-015 rx_ready  input  1  host pop; pop when rx_valid && rx_ready.
REQ-016 m_tx_data  output  8  byte presented to spi_master tx_data, held stable from m_start until byte completes.
REQ-017 m_start  output  1  one-cycle pulse launching one spi_master byte transfer.
REQ-018 m_rx_data  input  8  spi_master received byte.
REQ-019 m_rx_done  input  1  spi_master byte complete (level or pulse; rising edge used).

Function
REQ-020 FSM states IDLE, LOAD, WAIT, STORE, DONE; registered outputs.
REQ-021 IDLE -> LOAD on accepted burst_start; remaining counter <= burst_len.
REQ-022 burst_start with burst_len == 0, or outside IDLE, shall be ignored with no output change.
REQ-023 LOAD: if TX FIFO empty, stay in LOAD (no timeout); else pop one byte into m_tx_data, pulse m_start, go WAIT next cycle.
REQ-024 WAIT: on m_rx_done rising edge (0->1 detected against registered previous value) go STORE; timeout counter clears on entry.
REQ-025 WAIT: if TIMEOUT cycles elapse without edge, go DONE with error flag set; remaining TX bytes stay queued.
REQ-026 STORE: if RX FIFO full, stay in STORE; else push m_rx_data, decrement remaining; remaining==1 before decrement -> DONE, else LOAD.
REQ-027 DONE: burst_done=1 (burst_err=error flag) for exactly one cycle, clear error flag, return to IDLE.
REQ-028 Minimum per-byte latency: m_start one cycle after LOAD entry; STORE push one cycle after detected m_rx_done edge.
REQ-029 FIFOs: circular, log2(DEPTH) pointers wrap modulo DEPTH, separate count width log2(DEPTH)+1.
REQ-030 TX push when full, or RX pop when empty, shall be ignored; pointers unchanged.
REQ-031 Simultaneous host push and FSM pop on TX FIFO (non-full, non-empty) shall both occur, count unchanged; same for RX push/pop.
REQ-032 Host may push TX and pop RX in any state, including during a burst.
REQ-033 rx_data shall be valid combinationally from head entry whenever rx_valid=1.

Reset
REQ-034 reset low shall immediately force IDLE, empty both FIFOs, clear counters and error flag.
REQ-035 Reset values: tx_ready=1, busy=0, burst_done=0, burst_err=0, rx_valid=0, rx_data=0, m_tx_data=0, m_start=0.
REQ-036 Reset asserted mid-burst shall discard in-flight byte and all queued data; no burst_done generated.

Verification
REQ-037 Push 8'hB7, burst_len=1 start; model returns 8'hAD on m_rx_done -> m_tx_data=8'hB7, one m_start, rx_data=8'hAD, burst_done pulse, burst_err=0.
REQ-038 Push 8'hFB,8'h89,8'h01,8'h02 (FIFO full, tx_ready=0), 5th push ignored; burst_len=4 -> four m_start pulses in order, four RX bytes in order.
REQ-039 burst_len=3 with one byte queued -> FSM stalls in LOAD after first byte; later pushes resume burst, burst_done after third byte.
REQ-040 No m_rx_done for 64 cycles after m_start -> burst_done and burst_err pulse together, busy=0, nothing pushed to RX.
REQ-041 rx_ready=0, burst_len=6, DEPTH=4 -> stall in STORE after 4 bytes; pop one -> resumes; all 6 bytes received in order.
REQ-042 Assert reset during WAIT of 3-byte burst -> busy=0, tx_ready=1, rx_valid=0 immediately; no burst_done.
